// File: rtl/envelope_pkg.sv
// Shared widths and the saturating rectifier for the multichannel envelope detector.
package envelope_pkg;

  localparam int PCM_W = 16;
  localparam int ACC_W = 32;
  localparam logic [PCM_W-2:0] ENV_MAX = 15'h7FFF;

  // |x| in 15 bits; the lone unrepresentable magnitude (-32768) clips to ENV_MAX.
  function automatic logic [PCM_W-2:0] sat_abs(input logic signed [PCM_W-1:0] x);
    logic signed [PCM_W-1:0] mag;
    if (x == -16'sd32768) return ENV_MAX;
    mag = x[PCM_W-1] ? -x : x;
    return mag[PCM_W-2:0];
  endfunction

endpackage

// File: rtl/envelope_ch.sv
// One channel: rectify, one-pole smoother, decimation counter and a
// single-entry output register with valid/ready handshakes on both sides.
module envelope_ch
  import envelope_pkg::*;
#(
  parameter int DSW = 12
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    in_valid_i,
  output logic                    in_ready_o,
  input  logic signed [PCM_W-1:0] pcm_i,
  output logic                    env_valid_o,
  input  logic                    env_ready_i,
  output logic [PCM_W-1:0]        env_o,
  input  logic [3:0]              alpha_shift_i,
  input  logic [DSW-1:0]          down_sample_i,
  input  logic                    bypass_i
);

  logic [ACC_W-1:0] acc_q, acc_d, acc_upd;
  logic [DSW-1:0]   cnt_q, cnt_d, d_m1;
  logic [PCM_W-1:0] env_q, env_d;
  logic             full_q, full_d;
  logic [PCM_W-2:0] a;
  logic             accept, emit;

  assign in_ready_o  = !full_q || env_ready_i;
  assign accept      = in_valid_i && in_ready_o;
  assign env_valid_o = full_q;
  assign env_o       = env_q;

  always_comb begin
    a       = sat_abs(pcm_i);
    // acc stays below 32767<<16, so the add/subtract cannot wrap.
    acc_upd = acc_q + ({1'b0, a, 16'b0} >> alpha_shift_i) - (acc_q >> alpha_shift_i);
    d_m1    = (down_sample_i == '0) ? '0 : down_sample_i - 1'b1;
    emit    = bypass_i || (cnt_q >= d_m1);

    acc_d  = acc_q;
    cnt_d  = cnt_q;
    env_d  = env_q;
    full_d = full_q && !env_ready_i;
    if (accept) begin
      acc_d = acc_upd;
      cnt_d = emit ? '0 : cnt_q + 1'b1;
      if (emit) begin
        // A load in the drain cycle simply overwrites; valid stays high.
        env_d  = bypass_i ? {1'b0, a} : acc_upd[ACC_W-1:ACC_W-PCM_W];
        full_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      acc_q  <= '0;
      cnt_q  <= '0;
      env_q  <= '0;
      full_q <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      cnt_q  <= cnt_d;
      env_q  <= env_d;
      full_q <= full_d;
    end
  end

endmodule

// File: rtl/envelope_det_mc.sv
// Multichannel envelope detector: CHANNEL independent envelope_ch lanes
// sharing the smoothing, decimation and bypass controls.
module envelope_det_mc
  import envelope_pkg::*;
#(
  parameter int CHANNEL = 3,
  parameter int DSW     = 12
) (
  input  logic                     pcm_clk,
  input  logic                     rst,
  input  logic [CHANNEL-1:0]       pcm_in_valid,
  output logic [CHANNEL-1:0]       pcm_in_ready,
  input  logic [PCM_W*CHANNEL-1:0] pcm_in,
  output logic [CHANNEL-1:0]       env_out_valid,
  input  logic [CHANNEL-1:0]       env_out_ready,
  output logic [PCM_W*CHANNEL-1:0] env_out,
  input  logic [3:0]               alpha_shift,
  input  logic [DSW-1:0]           down_sample,
  input  logic                     bypass
);

  for (genvar i = 0; i < CHANNEL; i++) begin : g_ch
    envelope_ch #(.DSW(DSW)) u_ch (
      .clk_i         (pcm_clk),
      .rst_i         (rst),
      .in_valid_i    (pcm_in_valid[i]),
      .in_ready_o    (pcm_in_ready[i]),
      .pcm_i         (pcm_in[PCM_W*i +: PCM_W]),
      .env_valid_o   (env_out_valid[i]),
      .env_ready_i   (env_out_ready[i]),
      .env_o         (env_out[PCM_W*i +: PCM_W]),
      .alpha_shift_i (alpha_shift),
      .down_sample_i (down_sample),
      .bypass_i      (bypass)
    );
  end

endmodule

// File: tb/tb_envelope_det_mc.sv
// Directed bench for envelope_det_mc with hand-computed expectations.
module tb_envelope_det_mc;

  localparam int CH  = 3;
  localparam int DSW = 12;

  logic            pcm_clk = 1'b0;
  logic            rst = 1'b1;
  logic [CH-1:0]   pcm_in_valid = '0;
  logic [CH-1:0]   pcm_in_ready;
  logic [16*CH-1:0] pcm_in = '0;
  logic [CH-1:0]   env_out_valid;
  logic [CH-1:0]   env_out_ready = '1;
  logic [16*CH-1:0] env_out;
  logic [3:0]      alpha_shift = '0;
  logic [DSW-1:0]  down_sample = 12'd1;
  logic            bypass = 1'b0;

  int n_cmp = 0;
  int n_err = 0;

  envelope_det_mc #(.CHANNEL(CH), .DSW(DSW)) dut (
    .pcm_clk       (pcm_clk),
    .rst           (rst),
    .pcm_in_valid  (pcm_in_valid),
    .pcm_in_ready  (pcm_in_ready),
    .pcm_in        (pcm_in),
    .env_out_valid (env_out_valid),
    .env_out_ready (env_out_ready),
    .env_out       (env_out),
    .alpha_shift   (alpha_shift),
    .down_sample   (down_sample),
    .bypass        (bypass)
  );

  always #5 pcm_clk = ~pcm_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge pcm_clk);
    #1;
  endtask

  task automatic set_pcm(input int ch, input int val);
    pcm_in[16*ch +: 16] = 16'(val);
  endtask

  function automatic logic [15:0] env(input int ch);
    return env_out[16*ch +: 16];
  endfunction

  task automatic do_reset();
    pcm_in_valid = '0;
    env_out_ready = '1;
    bypass = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    // Reset state
    tick();
    chk("rst_valid", env_out_valid, 0);
    chk("rst_env", env_out, 0);
    chk("rst_ready", pcm_in_ready, 3'b111);
    rst = 1'b0;

    // k=0, D=1, -100 on ch0
    alpha_shift = 4'd0; down_sample = 12'd1;
    set_pcm(0, -100); pcm_in_valid = 3'b001;
    tick();
    pcm_in_valid = '0;
    chk("neg100_valid", env_out_valid, 3'b001);
    chk("neg100_env", env(0), 100);
    tick();
    chk("neg100_drained", env_out_valid, 0);

    // k=2, constant 16384 on ch1 -> 4096, 7168, 9472
    do_reset();
    alpha_shift = 4'd2;
    set_pcm(1, 16384); pcm_in_valid = 3'b010;
    tick(); chk("k2_s1", env(1), 4096);
    tick(); chk("k2_s2", env(1), 7168);
    tick(); chk("k2_s3", env(1), 9472);
    chk("k2_valid", env_out_valid, 3'b010);
    pcm_in_valid = '0;

    // Rectifier extremes on ch2
    do_reset();
    alpha_shift = 4'd0;
    pcm_in_valid = 3'b100;
    set_pcm(2, -32768); tick(); chk("sat_neg", env(2), 32767);
    set_pcm(2, 32767);  tick(); chk("sat_pos", env(2), 32767);
    set_pcm(2, 0);      tick(); chk("zero", env(2), 0);
    pcm_in_valid = '0;

    // D=4: 8 samples, outputs after 4th and 8th
    do_reset();
    down_sample = 12'd4;
    pcm_in_valid = 3'b001;
    for (int n = 1; n <= 8; n++) begin
      set_pcm(0, n * 100);
      tick();
      chk($sformatf("d4_valid_%0d", n), env_out_valid[0], (n % 4 == 0));
      if (n % 4 == 0) chk($sformatf("d4_env_%0d", n), env(0), n * 100);
    end
    pcm_in_valid = '0;

    // D=0 behaves as D=1
    down_sample = 12'd0;
    pcm_in_valid = 3'b001;
    set_pcm(0, 1234); tick();
    chk("d0_v1", env_out_valid[0], 1); chk("d0_e1", env(0), 1234);
    set_pcm(0, 55); tick();
    chk("d0_v2", env_out_valid[0], 1); chk("d0_e2", env(0), 55);
    pcm_in_valid = '0;

    // Backpressure on ch1
    do_reset();
    down_sample = 12'd1;
    env_out_ready = 3'b101;
    set_pcm(1, 500); pcm_in_valid = 3'b010;
    tick();
    chk("bp_ready_low", pcm_in_ready[1], 0);
    set_pcm(1, 700);
    tick();
    chk("bp_hold_valid", env_out_valid[1], 1);
    chk("bp_hold_env", env(1), 500);
    set_pcm(1, 600); env_out_ready = 3'b111;
    #1 chk("bp_ready_comb", pcm_in_ready[1], 1);
    tick();
    chk("bp_both_valid", env_out_valid[1], 1);
    chk("bp_both_env", env(1), 600);
    pcm_in_valid = '0;
    tick();
    chk("bp_drained", env_out_valid[1], 0);

    // Reset mid-stream, D=4, cnt=2
    do_reset();
    down_sample = 12'd4;
    pcm_in_valid = 3'b001;
    set_pcm(0, 900); tick();
    set_pcm(0, 800); tick();
    chk("mid_no_out", env_out_valid[0], 0);
    set_pcm(0, 999); rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_valid", env_out_valid, 0);
    chk("mid_rst_env", env_out, 0);
    chk("mid_rst_ready", pcm_in_ready, 3'b111);
    for (int n = 1; n <= 4; n++) begin
      set_pcm(0, n * 10);
      tick();
      chk($sformatf("mid_valid_%0d", n), env_out_valid[0], (n == 4));
    end
    chk("mid_env", env(0), 40);
    pcm_in_valid = '0;

    // Bypass: immediate rectified output, acc still updated
    do_reset();
    bypass = 1'b1; alpha_shift = 4'd2; down_sample = 12'd4;
    set_pcm(2, -300); pcm_in_valid = 3'b100;
    tick();
    chk("byp_valid", env_out_valid[2], 1);
    chk("byp_env", env(2), 300);
    bypass = 1'b0; alpha_shift = 4'd1; down_sample = 12'd1;
    set_pcm(2, 0);
    tick();
    chk("byp_acc_env", env(2), 37);
    pcm_in_valid = '0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
